// File: rtl/upscale_pkg.sv
// rtl/upscale_pkg.sv - shared geometry, width and FIFO-word layout constants for the 3x upscaler
//
// Purpose: single source for the upscale factor, raster sizes, pixel width and
//          the positions of the frame markers stored alongside each pixel.
// Ports:   none (package).
package upscale_pkg;

   localparam int SCALE      = 3;
   localparam int IMG_W      = 384;
   localparam int IMG_H      = 216;
   localparam int OUT_W      = SCALE * IMG_W;
   localparam int OUT_H      = SCALE * IMG_H;
   localparam int DATA_WIDTH = 24;

   // Marker bits sit directly above the pixel field in the FIFO word; these
   // are offsets from the pixel width, so the layout follows DATA_WIDTH.
   localparam int SB_EOF  = 0;
   localparam int SB_EOL  = 1;
   localparam int SB_SOF  = 2;
   localparam int SB_BITS = 3;

endpackage

// File: rtl/upscale_sync_fifo.sv
// rtl/upscale_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy output
//
// Purpose: small FWFT buffer; the head entry is always readable on rdata.
//          A push and a pop in the same cycle are both honoured, including
//          while full, leaving the level unchanged.
// Ports:   clk, rst (async, active-high), clr (sync flush),
//          push/wdata (write side), pop/rdata (read side, head entry),
//          level (occupancy 0..DEPTH), full.
// Callers must not push while full without a pop, nor pop while empty.
module upscale_sync_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // When full, wr_ptr equals rd_ptr: the head is read combinationally this
   // cycle and overwritten at the edge, which is what push-with-pop needs.
   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = (level_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/upscale_out_framer.sv
// rtl/upscale_out_framer.sv - tags upscaler pixels with frame markers and buffers them for a ready/valid sink
//
// Purpose: counts x/y over the OUT_W x OUT_H raster on every valid input
//          pixel, stores {sof, eol, eof, pixel} in a FWFT FIFO, presents the
//          head to the sink, latches overflow on drops and pulses frame_done
//          after the end-of-frame pixel leaves.
// Ports:   clk, rst (async, active-high), clr (sync flush);
//          pixel_in/input_valid (upscaler stream, no backpressure);
//          m_data/m_valid/m_ready/m_sof/m_eol/m_eof (sink interface);
//          level (FIFO occupancy), overflow (sticky), frame_done (pulse).
module upscale_out_framer #(
   parameter int DATA_WIDTH = upscale_pkg::DATA_WIDTH,
   parameter int OUT_W      = upscale_pkg::OUT_W,
   parameter int OUT_H      = upscale_pkg::OUT_H,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         pixel_in,
   input  logic                          input_valid,
   input  logic                          clr,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_sof,
   output logic                          m_eol,
   output logic                          m_eof,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          frame_done
);

   import upscale_pkg::*;

   localparam int WORD_W = DATA_WIDTH + SB_BITS;
   localparam int XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int LW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              overflow_q, overflow_d;
   logic              frame_done_q, frame_done_d;

   logic              fifo_full;
   logic [LW-1:0]     fifo_level;
   logic [WORD_W-1:0] wr_word, head_word;
   logic              head_valid, push, pop, drop;
   logic              at_sof, at_eol, at_eof;

   always_comb begin
      head_valid = (fifo_level != '0);
      // clr overrides both sides of the FIFO for this cycle.
      pop  = head_valid & m_ready & ~clr;
      push = input_valid & (~fifo_full | pop) & ~clr;
      drop = input_valid & fifo_full & ~pop & ~clr;

      at_sof = (x_q == '0) && (y_q == '0);
      at_eol = (x_q == X_LAST);
      at_eof = at_eol && (y_q == Y_LAST);

      wr_word                      = '0;
      wr_word[DATA_WIDTH-1:0]      = pixel_in;
      wr_word[DATA_WIDTH + SB_SOF] = at_sof;
      wr_word[DATA_WIDTH + SB_EOL] = at_eol;
      wr_word[DATA_WIDTH + SB_EOF] = at_eof;

      // Counters follow every valid input, stored or dropped, so the raster
      // stays aligned after an overflow.
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (input_valid) begin
         if (at_eol) begin
            x_d = '0;
            y_d = at_eof ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      overflow_d   = clr ? 1'b0 : (overflow_q | drop);
      frame_done_d = pop & head_word[DATA_WIDTH + SB_EOF];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   upscale_sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push),
      .wdata (wr_word),
      .pop   (pop),
      .rdata (head_word),
      .level (fifo_level),
      .full  (fifo_full)
   );

   // Stale storage is hidden behind m_valid so every output reads 0 in reset.
   assign m_valid    = head_valid;
   assign m_data     = head_valid ? head_word[DATA_WIDTH-1:0] : '0;
   assign m_sof      = head_valid & head_word[DATA_WIDTH + SB_SOF];
   assign m_eol      = head_valid & head_word[DATA_WIDTH + SB_EOL];
   assign m_eof      = head_valid & head_word[DATA_WIDTH + SB_EOF];
   assign level      = fifo_level;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_upscale_out_framer.sv
// tb/tb_upscale_out_framer.sv - self-checking bench for upscale_out_framer
module tb_upscale_out_framer;

   localparam int DW = 24;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] pixel_in = '0;
   logic          input_valid = 1'b0;
   logic          clr = 1'b0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_valid, m_sof, m_eol, m_eof, overflow, frame_done;
   logic [2:0]    level;

   upscale_out_framer #(
      .DATA_WIDTH (DW),
      .OUT_W      (W),
      .OUT_H      (H),
      .FIFO_DEPTH (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pixel_in    (pixel_in),
      .input_valid (input_valid),
      .clr         (clr),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_sof       (m_sof),
      .m_eol       (m_eol),
      .m_eof       (m_eof),
      .level       (level),
      .overflow    (overflow),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic          sof;
      logic          eol;
      logic          eof;
      logic [DW-1:0] px;
   } ent_t;

   // Reference model: a queue of tagged pixels plus a linear raster index.
   ent_t mq[$];
   ent_t m_new, m_old;
   int   pix_idx = 0;
   bit   ovf_m   = 0;
   bit   fd_m    = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         pix_idx = 0;
         ovf_m   = 0;
         fd_m    = 0;
      end else if (clr) begin
         mq.delete();
         pix_idx = 0;
         ovf_m   = 0;
         fd_m    = 0;
      end else begin
         fd_m = 0;
         if (mq.size() != 0 && m_ready) begin
            m_old = mq.pop_front();
            fd_m  = m_old.eof;
         end
         if (input_valid) begin
            if (mq.size() < D) begin
               m_new.sof = (pix_idx == 0);
               m_new.eol = ((pix_idx % W) == W - 1);
               m_new.eof = (pix_idx == W * H - 1);
               m_new.px  = pixel_in;
               mq.push_back(m_new);
            end else begin
               ovf_m = 1;
            end
            pix_idx = (pix_idx + 1) % (W * H);
         end
      end
   end

   // Compare process plus a log of what the DUT actually handed to the sink.
   bit   chk_en = 0;
   int   fd_cnt = 0;
   ent_t plog[$];
   ent_t cap;

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
         chk("level", 32'(level), 32'(mq.size()));
         if (mq.size() != 0) begin
            chk("m_data", 32'(m_data), 32'(mq[0].px));
            chk("m_sof", 32'(m_sof), 32'(mq[0].sof));
            chk("m_eol", 32'(m_eol), 32'(mq[0].eol));
            chk("m_eof", 32'(m_eof), 32'(mq[0].eof));
         end
         chk("overflow", 32'(overflow), 32'(ovf_m));
         chk("frame_done", 32'(frame_done), 32'(fd_m));
         if (frame_done) fd_cnt++;
         if (m_valid && m_ready && !clr) begin
            cap.sof = m_sof;
            cap.eol = m_eol;
            cap.eof = m_eof;
            cap.px  = m_data;
            plog.push_back(cap);
         end
      end
   end

   task automatic drive(input logic iv, input logic [DW-1:0] px, input logic rdy, input logic c);
      @(posedge clk);
      #1;
      input_valid = iv;
      pixel_in    = px;
      m_ready     = rdy;
      clr         = c;
   endtask

   int dd_seen;

   initial begin
      // Reset
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_sof", 32'(m_sof), 0);
      chk("rst_m_eol", 32'(m_eol), 0);
      chk("rst_m_eof", 32'(m_eof), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      rst    = 1'b0;
      chk_en = 1;
      repeat (5) drive(1'b0, '0, 1'b1, 1'b0);
      chk("idle_m_valid", 32'(m_valid), 0);
      chk("idle_level", 32'(level), 0);

      // Full frame streaming
      plog.delete();
      fd_cnt = 0;
      for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
      chk("frame_len", 32'(plog.size()), 8);
      for (int i = 0; i < 8 && i < plog.size(); i++) begin
         chk("frame_px", 32'(plog[i].px), 32'(i + 1));
         chk("frame_sof", 32'(plog[i].sof), 32'(i == 0));
         chk("frame_eol", 32'(plog[i].eol), 32'(i == 3 || i == 7));
         chk("frame_eof", 32'(plog[i].eof), 32'(i == 7));
      end
      chk("frame_done_count", 32'(fd_cnt), 1);
      chk("frame_overflow", 32'(overflow), 0);

      // Overflow
      plog.delete();
      for (int i = 0; i < 6; i++) drive(1'b1, DW'(32'hA1 + i), 1'b0, 1'b0);
      chk("ovf_level", 32'(level), 4);
      chk("ovf_flag", 32'(overflow), 1);
      repeat (5) drive(1'b0, '0, 1'b1, 1'b0);
      chk("ovf_pop_count", 32'(plog.size()), 4);
      for (int i = 0; i < 4 && i < plog.size(); i++)
         chk("ovf_pop_px", 32'(plog[i].px), 32'(32'hA1 + i));
      drive(1'b1, DW'(32'hB0), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("b0_valid", 32'(m_valid), 1);
      chk("b0_data", 32'(m_data), 32'hB0);
      chk("b0_eol", 32'(m_eol), 0);
      chk("b0_sof", 32'(m_sof), 0);
      chk("ovf_sticky", 32'(overflow), 1);
      drive(1'b0, '0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("clr_ovf", 32'(overflow), 0);
      chk("clr_level", 32'(level), 0);

      // Full with simultaneous pop and push
      for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'hD1 + i), 1'b0, 1'b0);
      drive(1'b1, DW'(32'hC0), 1'b1, 1'b0);
      chk("full_level", 32'(level), 4);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("pp_level", 32'(level), 4);
      chk("pp_overflow", 32'(overflow), 0);
      plog.delete();
      repeat (6) drive(1'b0, '0, 1'b1, 1'b0);
      chk("pp_drain", 32'(plog.size()), 4);
      if (plog.size() == 4) begin
         chk("pp_first", 32'(plog[0].px), 32'hD2);
         chk("pp_last", 32'(plog[3].px), 32'hC0);
      end

      // clr mid-frame
      for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'hE1 + i), 1'b0, 1'b0);
      drive(1'b1, DW'(32'hDD), 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("midclr_level", 32'(level), 0);
      chk("midclr_ovf", 32'(overflow), 0);
      chk("midclr_valid", 32'(m_valid), 0);
      plog.delete();
      drive(1'b1, DW'(32'hE7), 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("postclr_valid", 32'(m_valid), 1);
      chk("postclr_sof", 32'(m_sof), 1);
      chk("postclr_data", 32'(m_data), 32'hE7);
      repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
      dd_seen = 0;
      foreach (plog[i]) if (plog[i].px == DW'(32'hDD)) dd_seen++;
      chk("dd_never_out", 32'(dd_seen), 0);
      chk("postclr_count", 32'(plog.size()), 1);

      // Async reset mid-stream
      drive(1'b1, DW'(32'hF1), 1'b0, 1'b0);
      drive(1'b1, DW'(32'hF2), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(level), 2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(m_valid), 0);
      chk("arst_level", 32'(level), 0);
      chk("arst_ovf", 32'(overflow), 0);
      chk("arst_data", 32'(m_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, DW'(32'hF3), 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_sof", 32'(m_sof), 1);
      chk("post_rst_data", 32'(m_data), 32'hF3);

      // Randomized traffic against the model
      repeat (400)
         drive($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 49) == 0);
      repeat (6) drive(1'b0, '0, 1'b1, 1'b0);
      chk_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
